ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl_pkg.sv | 33 +++
 rtl/core_defines.vh | 21 ++
 rtl/ras_slot_select.sv | 59 +++++
 rtl/ras_ctrl.sv | 131 +++++++++++++
 tb/tb_ras_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ras_ctrl_pkg.sv
// Types and constants shared by the return-address-stack controller and its slot selector.
`include "core_defines.vh"

package ras_ctrl_pkg;

  localparam int FETCH_RATE = `FETCH_RATE_HW;
  localparam int BT_W       = `BRANCH_TYPE__LEN;
  localparam int SLOT_W     = (FETCH_RATE > 1) ? $clog2(FETCH_RATE) : 1;

  typedef enum logic [BT_W-1:0] {
    BR_NONE  = `BR_TYPE_NONE,
    BR_COND  = `BR_TYPE_COND,
    BR_JMP   = `BR_TYPE_JMP,
    BR_IJMP  = `BR_TYPE_IJMP,
    BR_CALL  = `BR_TYPE_CALL,
    BR_ICALL = `BR_TYPE_ICALL,
    BR_RET   = `BR_TYPE_RET,
    BR_COROU = `BR_TYPE_COROU
  } br_type_e;

  typedef enum logic [1:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_COROU
  } ras_op_e;

  // Only unconditional control transfers end the scan; conditional branches fall through.
  function automatic logic is_ctrl_type(logic [BT_W-1:0] bt);
    return (bt != BR_NONE) && (bt != BR_COND);
  endfunction

endpackage

// File: rtl/core_defines.vh
// Shared front-end definitions: fetch width, branch-type encodings and RAS sizing.
`ifndef CORE_DEFINES_VH
`define CORE_DEFINES_VH

`define FETCH_RATE_HW      4
`define BRANCH_TYPE__LEN   3

`define BR_TYPE_NONE   3'd0
`define BR_TYPE_COND   3'd1
`define BR_TYPE_JMP    3'd2
`define BR_TYPE_IJMP   3'd3
`define BR_TYPE_CALL   3'd4
`define BR_TYPE_ICALL  3'd5
`define BR_TYPE_RET    3'd6
`define BR_TYPE_COROU  3'd7

`define RAS_DEPTH_DEFAULT  8
// Checkpoint is {count, tos}: count needs one extra bit to represent a full stack.
`define RAS_CKPT_W(depth)  (2*$clog2(depth)+1)

`endif

// File: rtl/ras_slot_select.sv
// Priority encoder picking the first control-transfer slot of a fetch bundle.
// RAS_COROU_EN: when defined, COROU becomes a swap op; otherwise it behaves as ICALL.
`include "core_defines.vh"

module ras_slot_select
  import ras_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [BT_W*FETCH_RATE-1:0]   BranchType_Bus,
  input  logic [ADDR_W*FETCH_RATE-1:0] SlotPC_Bus,
  input  logic [FETCH_RATE-1:0]        SlotIs16_Bus,
  output logic                         active,
  output logic [SLOT_W-1:0]            slot,
  output ras_op_e                      op,
  output logic [ADDR_W-1:0]            link
);

  logic [BT_W-1:0]   bt_sel;
  logic [ADDR_W-1:0] pc_sel;
  logic              is16_sel;

  // Scan from the top down so the lowest matching slot is the last to write.
  always_comb begin
    active   = 1'b0;
    slot     = '0;
    bt_sel   = BR_NONE;
    pc_sel   = '0;
    is16_sel = 1'b0;
    for (int i = FETCH_RATE-1; i >= 0; i--) begin
      if (is_ctrl_type(BranchType_Bus[i*BT_W +: BT_W])) begin
        active   = 1'b1;
        slot     = SLOT_W'(i);
        bt_sel   = BranchType_Bus[i*BT_W +: BT_W];
        pc_sel   = SlotPC_Bus[i*ADDR_W +: ADDR_W];
        is16_sel = SlotIs16_Bus[i];
      end
    end
  end

  assign link = pc_sel + (is16_sel ? ADDR_W'(2) : ADDR_W'(4));

  always_comb begin
    op = RAS_OP_NONE;
    if (active) begin
      case (bt_sel)
        BR_CALL, BR_ICALL: op = RAS_OP_PUSH;
        BR_RET:            op = RAS_OP_POP;
`ifdef RAS_COROU_EN
        BR_COROU:          op = RAS_OP_COROU;
`else
        BR_COROU:          op = RAS_OP_PUSH;
`endif
        default:           op = RAS_OP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack controller: circular stack with {count, tos} checkpointing.
// RAS_COROU_EN (see ras_slot_select) enables coroutine swap handling.
`include "core_defines.vh"

module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int RAS_DEPTH = `RAS_DEPTH_DEFAULT,
  parameter int ADDR_W    = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            Stall,
  input  logic                            Bubble,
  input  logic [BT_W*FETCH_RATE-1:0]      BranchType_Bus,
  input  logic [ADDR_W*FETCH_RATE-1:0]    SlotPC_Bus,
  input  logic [FETCH_RATE-1:0]           SlotIs16_Bus,
  input  logic                            Restore,
  input  logic [`RAS_CKPT_W(RAS_DEPTH)-1:0] RestoreCkpt,
  output logic [`RAS_CKPT_W(RAS_DEPTH)-1:0] Ckpt,
  output logic                            RetValid,
  output logic [ADDR_W-1:0]               RetTarget,
  output logic [SLOT_W-1:0]               RetSlot
);

  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CKPT_W = `RAS_CKPT_W(RAS_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entries [RAS_DEPTH];

  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ret_valid_d;
  logic [ADDR_W-1:0] ret_target_d;
  logic [SLOT_W-1:0] ret_slot_d;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  logic              sel_active;
  logic [SLOT_W-1:0] sel_slot;
  ras_op_e           sel_op;
  logic [ADDR_W-1:0] sel_link;

  ras_slot_select #(.ADDR_W(ADDR_W)) u_slot_select (
    .BranchType_Bus (BranchType_Bus),
    .SlotPC_Bus     (SlotPC_Bus),
    .SlotIs16_Bus   (SlotIs16_Bus),
    .active         (sel_active),
    .slot           (sel_slot),
    .op             (sel_op),
    .link           (sel_link)
  );

  // Restore outranks everything; a stalled cycle otherwise keeps every register as is.
  always_comb begin
    tos_d        = tos_q;
    count_d      = count_q;
    ret_valid_d  = RetValid;
    ret_target_d = RetTarget;
    ret_slot_d   = RetSlot;
    wr_en        = 1'b0;
    wr_idx       = tos_q;
    if (Restore) begin
      tos_d        = RestoreCkpt[PTR_W-1:0];
      count_d      = RestoreCkpt[CKPT_W-1:PTR_W];
      ret_valid_d  = 1'b0;
      ret_target_d = '0;
      ret_slot_d   = '0;
    end else if (!Stall) begin
      ret_valid_d  = 1'b0;
      ret_target_d = '0;
      ret_slot_d   = '0;
      if (!Bubble && sel_active) begin
        ret_slot_d = sel_slot;
        case (sel_op)
          RAS_OP_PUSH: begin
            tos_d   = tos_q + 1'b1;
            wr_en   = 1'b1;
            wr_idx  = tos_q + 1'b1;
            count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
          end
          RAS_OP_POP: begin
            if (count_q != '0) begin
              ret_valid_d  = 1'b1;
              ret_target_d = entries[tos_q];
              tos_d        = tos_q - 1'b1;
              count_d      = count_q - 1'b1;
            end
          end
          RAS_OP_COROU: begin
            wr_en = 1'b1;
            if (count_q != '0) begin
              ret_valid_d  = 1'b1;
              ret_target_d = entries[tos_q];
            end else begin
              count_d = CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Entry storage is deliberately left unreset; count guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) entries[wr_idx] <= sel_link;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q     <= '0;
      count_q   <= '0;
      RetValid  <= 1'b0;
      RetTarget <= '0;
      RetSlot   <= '0;
    end else begin
      tos_q     <= tos_d;
      count_q   <= count_d;
      RetValid  <= ret_valid_d;
      RetTarget <= ret_target_d;
      RetSlot   <= ret_slot_d;
    end
  end

  assign Ckpt = {count_q, tos_q};

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: vector table plus hand sequences for overflow, restore and stall.
module tb_ras_ctrl;
  import ras_ctrl_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DEPTH  = 8;
  localparam int CKW    = 7;

  logic                         clk;
  logic                         rst_n;
  logic                         Stall;
  logic                         Bubble;
  logic [BT_W*FETCH_RATE-1:0]   BranchType_Bus;
  logic [ADDR_W*FETCH_RATE-1:0] SlotPC_Bus;
  logic [FETCH_RATE-1:0]        SlotIs16_Bus;
  logic                         Restore;
  logic [CKW-1:0]               RestoreCkpt;
  logic [CKW-1:0]               Ckpt;
  logic                         RetValid;
  logic [ADDR_W-1:0]            RetTarget;
  logic [SLOT_W-1:0]            RetSlot;

  int checks = 0;
  int errors = 0;

  ras_ctrl #(.RAS_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Stall          (Stall),
    .Bubble         (Bubble),
    .BranchType_Bus (BranchType_Bus),
    .SlotPC_Bus     (SlotPC_Bus),
    .SlotIs16_Bus   (SlotIs16_Bus),
    .Restore        (Restore),
    .RestoreCkpt    (RestoreCkpt),
    .Ckpt           (Ckpt),
    .RetValid       (RetValid),
    .RetTarget      (RetTarget),
    .RetSlot        (RetSlot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    br_type_e          bt [FETCH_RATE];
    logic [ADDR_W-1:0] pc_base;
    logic [3:0]        is16;
    logic              bubble;
    logic              ev;
    logic              tz;
    logic [ADDR_W-1:0] et;
    logic [SLOT_W-1:0] es;
    logic [CKW-1:0]    eck;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(br_type_e b0, br_type_e b1, br_type_e b2, br_type_e b3,
                              logic [ADDR_W-1:0] base, logic [3:0] is16, logic bubble,
                              logic ev, logic tz, logic [ADDR_W-1:0] et,
                              logic [SLOT_W-1:0] es, logic [CKW-1:0] eck);
    vec_t v;
    v.bt[0] = b0; v.bt[1] = b1; v.bt[2] = b2; v.bt[3] = b3;
    v.pc_base = base; v.is16 = is16; v.bubble = bubble;
    v.ev = ev; v.tz = tz; v.et = et; v.es = es; v.eck = eck;
    return v;
  endfunction

  // Slot i carries PC base + 4*i.
  task automatic applyStimulus(br_type_e b0, br_type_e b1, br_type_e b2, br_type_e b3,
                               logic [ADDR_W-1:0] base, logic [3:0] is16,
                               logic bubble, logic stall, logic restore, logic [CKW-1:0] rckpt);
    BranchType_Bus[0*BT_W +: BT_W] = b0;
    BranchType_Bus[1*BT_W +: BT_W] = b1;
    BranchType_Bus[2*BT_W +: BT_W] = b2;
    BranchType_Bus[3*BT_W +: BT_W] = b3;
    for (int i = 0; i < FETCH_RATE; i++)
      SlotPC_Bus[i*ADDR_W +: ADDR_W] = base + ADDR_W'(4*i);
    SlotIs16_Bus = is16;
    Bubble       = bubble;
    Stall        = stall;
    Restore      = restore;
    RestoreCkpt  = rckpt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [ADDR_W-1:0] act, logic [ADDR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic ev, logic tz, logic [ADDR_W-1:0] et,
                             logic [SLOT_W-1:0] es, logic [CKW-1:0] eck);
    chk({name, ".RetValid"}, ADDR_W'(RetValid), ADDR_W'(ev));
    chk({name, ".Ckpt"}, ADDR_W'(Ckpt), ADDR_W'(eck));
    if (ev || tz) chk({name, ".RetTarget"}, RetTarget, et);
    if (ev) chk({name, ".RetSlot"}, ADDR_W'(RetSlot), ADDR_W'(es));
  endtask

  task automatic idle();
    applyStimulus(BR_NONE, BR_NONE, BR_NONE, BR_NONE, '0, 4'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic call0(logic [ADDR_W-1:0] pc);
    applyStimulus(BR_CALL, BR_NONE, BR_NONE, BR_NONE, pc, 4'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic ret0(logic stall);
    applyStimulus(BR_RET, BR_NONE, BR_NONE, BR_NONE, '0, 4'b0, 1'b0, stall, 1'b0, '0);
  endtask

  initial begin
    int mtos;
    int mcnt;

    // Table: state carries over from one record to the next, starting empty.
    vecs.push_back(mk(BR_CALL, BR_NONE, BR_NONE, BR_NONE, 64'h1000, 4'b0000, 0, 0, 0, 0, 0, 7'h09));
    vecs.push_back(mk(BR_NONE, BR_RET,  BR_NONE, BR_NONE, 64'h2000, 4'b0000, 0, 1, 0, 64'h1004, 1, 7'h00));
    vecs.push_back(mk(BR_COND, BR_CALL, BR_NONE, BR_NONE, 64'h1FFE, 4'b0010, 0, 0, 0, 0, 0, 7'h09));
    vecs.push_back(mk(BR_JMP,  BR_RET,  BR_NONE, BR_NONE, 64'h0000, 4'b0000, 0, 0, 0, 0, 0, 7'h09));
    vecs.push_back(mk(BR_RET,  BR_CALL, BR_NONE, BR_NONE, 64'h0000, 4'b0000, 0, 1, 0, 64'h2004, 0, 7'h00));
    vecs.push_back(mk(BR_RET,  BR_NONE, BR_NONE, BR_NONE, 64'h0000, 4'b0000, 0, 0, 1, 0, 0, 7'h00));
    vecs.push_back(mk(BR_CALL, BR_NONE, BR_NONE, BR_NONE, 64'h5000, 4'b0000, 1, 0, 0, 0, 0, 7'h00));
    vecs.push_back(mk(BR_NONE, BR_NONE, BR_NONE, BR_NONE, 64'h6000, 4'b0000, 0, 0, 0, 0, 0, 7'h00));
`ifdef RAS_COROU_EN
    vecs.push_back(mk(BR_NONE, BR_COND, BR_COROU, BR_NONE, 64'h2FF8, 4'b0100, 0, 0, 1, 0, 0, 7'h08));
    vecs.push_back(mk(BR_NONE, BR_NONE, BR_COND, BR_RET,  64'h7000, 4'b0000, 0, 1, 0, 64'h3002, 3, 7'h07));
`else
    vecs.push_back(mk(BR_NONE, BR_COND, BR_COROU, BR_NONE, 64'h2FF8, 4'b0100, 0, 0, 0, 0, 0, 7'h09));
    vecs.push_back(mk(BR_NONE, BR_NONE, BR_COND, BR_RET,  64'h7000, 4'b0000, 0, 1, 0, 64'h3002, 3, 7'h00));
`endif

    rst_n = 1'b0;
    idle();
    #1;
    checkOutput("reset", 1'b0, 1'b1, '0, '0, 7'h00);
    chk("reset.RetSlot", ADDR_W'(RetSlot), '0);
    step();
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].bt[0], vecs[i].bt[1], vecs[i].bt[2], vecs[i].bt[3],
                    vecs[i].pc_base, vecs[i].is16, vecs[i].bubble, 1'b0, 1'b0, '0);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].tz, vecs[i].et, vecs[i].es, vecs[i].eck);
    end

    // Overflow: 9 calls into 8 entries, then drain with 9 returns.
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    step();
    mtos = 0;
    mcnt = 0;
    for (int k = 1; k <= 9; k++) begin
      call0(ADDR_W'(k * 'h100));
      step();
      mtos = (mtos + 1) % DEPTH;
      mcnt = (mcnt < DEPTH) ? mcnt + 1 : mcnt;
      checkOutput($sformatf("ovf_call%0d", k), 1'b0, 1'b0, '0, '0, CKW'((mcnt << 3) | mtos));
    end
    for (int j = 0; j < 9; j++) begin
      ret0(1'b0);
      step();
      if (mcnt > 0) begin
        mtos = (mtos + DEPTH - 1) % DEPTH;
        mcnt = mcnt - 1;
        checkOutput($sformatf("ovf_ret%0d", j), 1'b1, 1'b0, ADDR_W'((9 - j) * 'h100 + 4), '0,
                    CKW'((mcnt << 3) | mtos));
      end else begin
        checkOutput($sformatf("ovf_ret%0d", j), 1'b0, 1'b1, '0, '0, CKW'((mcnt << 3) | mtos));
      end
    end

    // Reset asserted between edges aborts the stack and forces the empty state at once.
    call0(64'h9000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst", 1'b0, 1'b1, '0, '0, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    checkOutput("post_rst", 1'b0, 1'b0, '0, '0, 7'h00);

    // Checkpoint after two calls, then restore it underneath a stall.
    call0(64'hA000); step();
    call0(64'hB000); step();
    checkOutput("ckpt_cap", 1'b0, 1'b0, '0, '0, 7'h12);
    call0(64'hC000); step();
    call0(64'hD000); step();
    call0(64'hE000); step();
    checkOutput("ckpt_5", 1'b0, 1'b0, '0, '0, 7'h2D);
    applyStimulus(BR_CALL, BR_NONE, BR_NONE, BR_NONE, 64'hF000, 4'b0, 1'b0, 1'b1, 1'b1, 7'h12);
    step();
    checkOutput("restore", 1'b0, 1'b0, '0, '0, 7'h12);
    ret0(1'b0);
    step();
    checkOutput("restore_ret", 1'b1, 1'b0, 64'hB004, '0, 7'h09);

    // Stalled RETs must leave the previous prediction frozen.
    for (int s = 0; s < 3; s++) begin
      ret0(1'b1);
      step();
      checkOutput($sformatf("stall%0d", s), 1'b1, 1'b0, 64'hB004, '0, 7'h09);
    end
    ret0(1'b0);
    step();
    checkOutput("unstall_ret", 1'b1, 1'b0, 64'hA004, '0, 7'h00);
    idle();
    step();
    checkOutput("final_idle", 1'b0, 1'b0, '0, '0, 7'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
